// File: rtl/addn_serial.sv
// addn_serial: multi-cycle ripple adder. Each RUN cycle adds DIGIT bits of
// both operands plus a registered carry, so only one DIGIT-wide adder slice is
// needed for a WIDTH-bit add. The handshake on both sides is valid/ready.
//
// Optional feature macro: ADDN_SERIAL_SUB_EN
//   When defined, an extra `sub` input is sampled together with the operands.
//   sub=1 computes a + ~b + 1, ignoring carry_in; carry_out=1 then means no borrow.
module addn_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDN_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Operand and carry values captured at accept. In subtract mode, b is
    // inverted and the carry is forced to 1. This gives a + ~b + 1 on the
    // same add path.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef ADDN_SERIAL_SUB_EN
    // Select between add and subtract operand forms at accept time
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : carry_in;
    end
`else
    // Add-only build: operands pass straight through
    always_comb begin
        b_load = b;
        c_load = carry_in;
    end
`endif

    // Single DIGIT-wide adder slice working on the low digit of each operand
    logic [DIGIT:0] dsum;
    logic           msb_cin;

    // Digit sum plus the carry into the digit's top bit. On the final step,
    // that top bit is the word's MSB, which is used for signed overflow.
    always_comb begin
        dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
        msb_cin = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    end

    // Control FSM and datapath with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b_load;
                        carry    <= c_load;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Sum digits enter at the MSB end. After STEPS shifts,
                    // the first digit has reached bit 0.
                    out   <= WIDTH'({dsum[DIGIT-1:0], out} >> DIGIT);
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        carry_out <= dsum[DIGIT];
                        overflow  <= msb_cin ^ dsum[DIGIT];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Input and output are not bypassed: the block reopens
                    // only after the result has been taken.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addn_serial.sv
// Directed and random bench for addn_serial (8/1 main instance, 16/4 wide instance).
module tb_addn_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [15:0] w_a = '0;
    logic [15:0] w_b = '0;
    logic        w_cin = 1'b0;
    logic        w_sub = 1'b0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic [15:0] w_sum;
    logic        w_cout;
    logic        w_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addn_serial #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(cin),
`ifdef ADDN_SERIAL_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out(sum),
        .carry_out(cout), .overflow(ovf)
    );

    addn_serial #(.WIDTH(16), .DIGIT(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .carry_in(w_cin),
`ifdef ADDN_SERIAL_SUB_EN
        .sub(w_sub),
`endif
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out(w_sum),
        .carry_out(w_cout), .overflow(w_ovf)
    );

    // Drive one op into the 8-bit DUT; return result and latency (edges after accept).
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input logic ts, output logic [9:0] res, output int lat,
                         output logic ok);
        ok = 1'b0;
        lat = 0;
        res = '0;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
            if (out_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        res = {ovf, cout, sum};
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b out=%h co=%b ov=%b, want rdy=1 vld=0 out=00 co=0 ov=0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        checks++;
        if ({w_in_ready, w_out_valid, w_sum} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state_wide: got rdy=%b vld=%b out=%h", w_in_ready, w_out_valid, w_sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic check_vec(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                             input logic tc, input logic ts, input logic [9:0] exp_res);
        logic [9:0] r;
        int         lat;
        logic       ok;
        do_op(ta, tb_, tc, ts, r, lat, ok);
        checks++;
        if (!ok || r !== exp_res || lat != 8) begin
            errors++;
            $display("FAIL %s: got ov/co/out=%b/%b/%h lat=%0d done=%b, want %b/%b/%h lat=8",
                     name, r[9], r[8], r[7:0], lat, ok, exp_res[9], exp_res[8], exp_res[7:0]);
        end
        take_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: got vld=%b rdy=%b, want vld=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        check_vec("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
        check_vec("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
        check_vec("80_plus_80", 8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00});
        check_vec("55_aa_cin",  8'h55, 8'hAA, 1'b1, 1'b0, {1'b0, 1'b1, 8'h00});
        check_vec("zero_cin",   8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'h01});
        check_vec("3c_plus_0f", 8'h3C, 8'h0F, 1'b0, 1'b0, {1'b0, 1'b0, 8'h4B});
    endtask

    task automatic test_backpressure();
        logic [9:0] r;
        int         lat;
        logic       ok;
        do_op(8'h12, 8'h34, 1'b0, 1'b0, r, lat, ok);
        checks++;
        if (!ok || r !== {1'b0, 1'b0, 8'h46}) begin
            errors++;
            $display("FAIL bp_result: got %h done=%b, want 046", r, ok);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || sum !== 8'h46 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b out=%h rdy=%b, want vld=1 out=46 rdy=0",
                         i, out_valid, sum, in_ready);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'h01; b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h46) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b out=%h, want vld=0 rdy=1 out=46",
                     out_valid, in_ready, sum);
        end
        check_vec("bp_second", 8'h21, 8'h43, 1'b1, 1'b0, {1'b0, 1'b0, 8'h65});
    endtask

    task automatic test_wide();
        int lat = 0;
        logic ok = 1'b0;
        @(negedge clk);
        w_in_valid = 1'b1; w_a = 16'h1234; w_b = 16'hEDCB; w_cin = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            w_in_valid = 1'b0; w_a = 16'hFFFF; w_b = 16'hFFFF;
            if (w_out_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        checks++;
        if (!ok || lat != 4 || {w_ovf, w_cout, w_sum} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL wide_add: got ov/co/out=%b/%b/%h lat=%0d done=%b, want 0/1/0000 lat=4",
                     w_ovf, w_cout, w_sum, lat, ok);
        end
        w_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_out_ready = 1'b0;
        checks++;
        if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wide_release: got vld=%b rdy=%b", w_out_valid, w_in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_run: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL rst_stale_valid: got vld=1 at cycle %0d, want 0", i);
                break;
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_idle_ready: got rdy=%b, want 1", in_ready);
        end
        check_vec("after_reset", 8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10});
    endtask

`ifdef ADDN_SERIAL_SUB_EN
    task automatic test_sub();
        check_vec("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
        check_vec("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1, {1'b0, 1'b1, 8'h02});
    endtask
`endif

    task automatic test_random();
        logic [9:0] r;
        logic [8:0] s;
        logic       eov;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         lat;
        logic       ok;
        int         bad = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            s = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            eov = (ra[7] == rb[7]) && (s[7] != ra[7]);
            do_op(ra, rb, rc, 1'b0, r, lat, ok);
            checks++;
            if (!ok || r !== {eov, s} || lat != 8) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_%0d: %h+%h+%b got ov/co/out=%b/%b/%h lat=%0d, want %b/%b/%h lat=8",
                             n, ra, rb, rc, r[9], r[8], r[7:0], lat, eov, s[8], s[7:0]);
            end
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_wide();
        test_reset_mid_run();
`ifdef ADDN_SERIAL_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
